irq_arbiter: RTL and testbench

- Interrupt controller between the peripheral interrupt sources (timer, external, software) and the pipeline's trap logic.
- Registers level requests, masks them with a programmable enable mask and the CPU global interrupt enable, and selects one winner.
- Presents the winner to the CPU with an ID and a request/take handshake, pulses the acknowledge back to the winning source, then blocks further requests until the handler returns.
- Source 0 is wired to the timer (timer_int / timer_int_ack).

---
 rtl/irq_arbiter.sv | 164 ++++++++++++++++
 tb/tb_irq_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter: registers level interrupt requests, masks them with en_mask and gie,
// picks one winner and runs a request/take/done handshake with the pipeline.
// Latency: a request rising at edge N shows irq=1 after edge N+2; all outputs registered.
// Backpressure: the winner is held in REQ until irq_take; no new request is presented
// until irq_done returns the block to IDLE.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   src_req / src_ack   level requests in, one-hot single-cycle acknowledge out
//   gie                 CPU global interrupt enable
//   irq / irq_id        request and winner index to the pipeline
//   irq_take / irq_done trap committed / handler returned
//   cfg_we / cfg_wdata  enable-mask write; en_mask is the readback
//   busy                high while a handler is in service
// Optional feature: define IRQ_RR_EN for round-robin arbitration (default fixed
// lowest-index priority).
module irq_arbiter #(
  parameter int                  NUM_SRC    = 4,
  parameter int                  ID_W       = 2,
  parameter logic [NUM_SRC-1:0]  RESET_MASK = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_req,
  output logic [NUM_SRC-1:0] src_ack,
  input  logic               gie,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_take,
  input  logic               irq_done,
  input  logic               cfg_we,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [NUM_SRC-1:0] en_mask,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] req_q;
  logic [NUM_SRC-1:0] blk;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] cur_oh;
  logic               cur_ok;
  logic               win_vld;
  logic [ID_W-1:0]    win_idx;

  assign elig    = req_q & en_mask & ~blk;
  assign win_vld = |elig;

  // One-hot form of the presented winner; used for the ack, the block bit and
  // the withdraw test without indexing by irq_id.
  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cur_oh[i] = (ID_W'(i) == irq_id);
    end
  end

  // The presented winner is still wanted: still enabled and still requesting.
  assign cur_ok = |(cur_oh & en_mask & req_q);

`ifdef IRQ_RR_EN
  logic [NUM_SRC-1:0] last_grant;  // one-hot, last source that was taken
  int                 last_idx;
  int                 dist;
  int                 best;

  // Pick the eligible source closest after last_grant (wrapping).
  always_comb begin
    last_idx = 0;
    dist     = 0;
    best     = NUM_SRC;
    win_idx  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (last_grant[i]) last_idx = i;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i]) begin
        dist = (i + NUM_SRC - last_idx - 1) % NUM_SRC;
        if (dist < best) begin
          best    = dist;
          win_idx = ID_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= {1'b1, {(NUM_SRC-1){1'b0}}};
    end else if (state == REQ && irq_take) begin
      last_grant <= cur_oh;
    end
  end
`else
  // Fixed priority: scan downwards so the lowest eligible index wins.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win_idx = ID_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= '0;
      blk     <= '0;
      en_mask <= RESET_MASK;
      irq     <= 1'b0;
      irq_id  <= '0;
      src_ack <= '0;
      busy    <= 1'b0;
    end else begin
      req_q   <= src_req;
      src_ack <= '0;
      if (cfg_we) en_mask <= cfg_wdata;

      // A block bit lives until the source's dropped request reaches req_q;
      // this covers the ack-to-req_q lag so an early irq_done cannot re-raise it.
      blk <= blk & req_q;

      case (state)
        IDLE: begin
          if (gie && win_vld) begin
            irq    <= 1'b1;
            irq_id <= win_idx;
            state  <= REQ;
          end
        end
        REQ: begin
          // Take has priority over withdraw: the trap is already committed.
          if (irq_take) begin
            irq     <= 1'b0;
            src_ack <= cur_oh;
            blk     <= (blk & req_q) | cur_oh;
            busy    <= 1'b1;
            state   <= SERVICE;
          end else if (!gie || !cur_ok) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        SERVICE: begin
          if (irq_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          irq   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: timer path, priority and withdraw, take/withdraw
// collisions, early irq_done, reset mid-service, and grant order under full load.
module tb_irq_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] src_req = '0;
  logic [3:0] src_ack;
  logic       gie = 1'b0;
  logic       irq;
  logic [1:0] irq_id;
  logic       irq_take = 1'b0;
  logic       irq_done = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_wdata = '0;
  logic [3:0] en_mask;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  irq_arbiter #(.NUM_SRC(4), .ID_W(2), .RESET_MASK(4'hF)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_req   (src_req),
    .src_ack   (src_ack),
    .gie       (gie),
    .irq       (irq),
    .irq_id    (irq_id),
    .irq_take  (irq_take),
    .irq_done  (irq_done),
    .cfg_we    (cfg_we),
    .cfg_wdata (cfg_wdata),
    .en_mask   (en_mask),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_irq(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (irq) break;
      step();
    end
  endtask

  logic [1:0] exp_id;

  initial begin
    // ---------------- reset state ----------------
    step(2);
    check("rst_irq", irq, 0);
    check("rst_irq_id", irq_id, 0);
    check("rst_src_ack", src_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_en_mask", en_mask, 4'hF);
    reset = 1'b0;
    gie   = 1'b1;
    step(3);

    // ---------------- basic timer path ----------------
    src_req = 4'b0001;
    step();
    check("t_lat1_irq", irq, 0);
    step();
    check("t_irq", irq, 1);
    check("t_irq_id", irq_id, 0);
    step(2);
    check("t_hold_irq", irq, 1);
    irq_take = 1'b1;
    step();
    irq_take = 1'b0;
    check("t_ack", src_ack, 4'b0001);
    check("t_busy", busy, 1);
    check("t_irq_low", irq, 0);
    src_req = 4'b0000;
    step();
    check("t_ack_1cyc", src_ack, 0);
    step(2);
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    check("t_done_busy", busy, 0);
    step(3);
    check("t_no_reraise", irq, 0);

    // ---------------- priority / withdraw ----------------
    src_req = 4'b1010;
    step(2);
    check("p_irq", irq, 1);
    check("p_irq_id", irq_id, 1);
    cfg_we    = 1'b1;
    cfg_wdata = 4'b1000;
    step();
    cfg_we = 1'b0;
    check("p_mask", en_mask, 4'b1000);
    step();
    check("p_withdraw", irq, 0);
    check("p_no_ack", src_ack, 0);
    step();
    check("p_rearb_irq", irq, 1);
    check("p_rearb_id", irq_id, 3);

    // ---------------- gie withdraw, then take colliding with gie fall ----------------
    gie = 1'b0;
    step();
    check("g_withdraw", irq, 0);
    check("g_no_ack", src_ack, 0);
    gie = 1'b1;
    step();
    check("g_reraise_id", irq_id, 3);
    gie      = 1'b0;
    irq_take = 1'b1;
    step();
    irq_take = 1'b0;
    check("g_take_ack", src_ack, 4'b1000);
    check("g_take_busy", busy, 1);
    src_req = 4'b0000;
    step(3);
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    check("g_done_busy", busy, 0);
    gie       = 1'b1;
    cfg_we    = 1'b1;
    cfg_wdata = 4'b0110;
    step();
    cfg_we = 1'b0;

    // ---------------- immediate irq_done ----------------
    src_req = 4'b0100;
    step(2);
    check("d_irq_id", irq_id, 2);
    irq_take = 1'b1;
    step();
    irq_take = 1'b0;
    check("d_ack", src_ack, 4'b0100);
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    check("d_busy", busy, 0);
    step();               // source still high one more cycle, req_q still 1
    src_req = 4'b0000;
    check("d_blk_irq0", irq, 0);
    step(3);
    check("d_blk_irq1", irq, 0);
    src_req = 4'b0100;
    step(2);
    check("d_blk_clear", irq, 1);
    check("d_blk_clear_id", irq_id, 2);

    // ---------------- reset mid-SERVICE ----------------
    irq_take = 1'b1;
    step();
    irq_take = 1'b0;
    check("r_pre_busy", busy, 1);
    check("r_pre_mask", en_mask, 4'b0110);
    reset = 1'b1;
    #2;
    check("r_irq", irq, 0);
    check("r_ack", src_ack, 0);
    check("r_busy", busy, 0);
    check("r_mask", en_mask, 4'hF);
    check("r_irq_id", irq_id, 0);
    step();
    reset = 1'b0;
    step();
    check("r_lat1_irq", irq, 0);
    step();
    check("r_reraise", irq, 1);
    check("r_reraise_id", irq_id, 2);

    // ---------------- grant order under full load ----------------
    reset = 1'b1;
    src_req = 4'b0000;
    step();
    reset = 1'b0;
    step();
    src_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
`ifdef IRQ_RR_EN
      exp_id = 2'(g % 4);
`else
      exp_id = 2'd0;
`endif
      wait_irq(10);
      check("o_irq", irq, 1);
      check("o_id", irq_id, exp_id);
      irq_take = 1'b1;
      step();
      irq_take = 1'b0;
      check("o_ack", src_ack, 4'b0001 << exp_id);
      src_req[exp_id] = 1'b0;
      step(3);
      src_req[exp_id] = 1'b1;
      step(2);
      irq_done = 1'b1;
      step();
      irq_done = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
